// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit between the pipeline and a
// single-port data memory. It takes one request at a time, drives one memory
// access (byte lanes and replicated store data), then holds the extended load
// result until write-back accepts it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side is ready only in IDLE. The response side holds
// resp_valid and its payload steady until resp_ready is sampled high. The
// memory side has no ready: dmem_en and its payload stay steady until a cycle
// with dmem_ack high.
//
// Build option: define MISALIGN_EXC_EN to report misaligned requests through
// resp_exc without touching memory. Without it, misaligned addresses are
// rounded down to the access size and the access proceeds.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        dmem_en,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_exc
);

`ifdef MISALIGN_EXC_EN
  localparam logic ExcEnable = 1'b1;
`else
  localparam logic ExcEnable = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stateT;

  stateT state, stateNext;

  // Captured request and result.
  logic        weR;
  logic [1:0]  sizeR;
  logic        signedR;
  logic [1:0]  offR;
  logic [3:0]  beR;
  logic [31:0] addrR;
  logic [31:0] wdataR;
  logic [31:0] rdataR;
  logic        excR;

  // Decoded view of the incoming request.
  logic [1:0]  sizeN;
  logic        misaligned;
  logic        takeExc;
  logic [1:0]  offN;
  logic [3:0]  beN;
  logic [31:0] wdataN;

  // Extracted load value.
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  // Decode the request: size 11 acts as word, the offset is rounded down to
  // the access size, and byte lanes/store data follow the rounded offset.
  always_comb begin
    sizeN      = (req_size == 2'b11) ? 2'b10 : req_size;
    misaligned = 1'b0;
    offN       = req_addr[1:0];
    beN        = 4'b1111;
    wdataN     = req_wdata;
    case (sizeN)
      2'b00: begin
        offN   = req_addr[1:0];
        beN    = 4'b0001 << req_addr[1:0];
        wdataN = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        offN       = {req_addr[1], 1'b0};
        beN        = 4'b0011 << {req_addr[1], 1'b0};
        wdataN     = {2{req_wdata[15:0]}};
      end
      default: begin
        misaligned = |req_addr[1:0];
        offN       = 2'b00;
        beN        = 4'b1111;
        wdataN     = req_wdata;
      end
    endcase
    takeExc = ExcEnable & misaligned;
  end

  // Pick the addressed byte or half out of the read word and extend it.
  always_comb begin
    byteSel  = dmem_rdata[{offR, 3'b000} +: 8];
    halfSel  = dmem_rdata[{offR[1], 4'b0000} +: 16];
    loadData = dmem_rdata;
    case (sizeR)
      2'b00:   loadData = {{24{signedR & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{signedR & halfSel[15]}}, halfSel};
      default: loadData = dmem_rdata;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state: accept in IDLE, wait for ack in ACCESS, wait for WB in RESP.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req_valid) stateNext = takeExc ? RESP : ACCESS;
      ACCESS:  if (dmem_ack) stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture the request on acceptance and the result on the ack edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weR     <= 1'b0;
      sizeR   <= 2'b00;
      signedR <= 1'b0;
      offR    <= 2'b00;
      beR     <= 4'b0000;
      addrR   <= 32'd0;
      wdataR  <= 32'd0;
      rdataR  <= 32'd0;
      excR    <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      weR     <= req_we;
      sizeR   <= sizeN;
      signedR <= req_signed;
      offR    <= offN;
      beR     <= req_we ? beN : 4'b0000;
      addrR   <= {req_addr[31:2], 2'b00};
      wdataR  <= wdataN;
      rdataR  <= 32'd0;
      excR    <= takeExc;
    end else if (state == ACCESS && dmem_ack) begin
      rdataR  <= weR ? 32'd0 : loadData;
    end
  end

  // Outputs follow the state; lanes are only enabled while accessing.
  always_comb begin
    req_ready  = (state == IDLE);
    dmem_en    = (state == ACCESS);
    dmem_be    = (state == ACCESS) ? beR : 4'b0000;
    dmem_addr  = addrR;
    dmem_wdata = wdataR;
    resp_valid = (state == RESP);
    resp_rdata = rdataR;
    resp_exc   = ExcEnable & excR;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives mem_access_unit with directed and random
// requests, plays the data memory, and checks every output each cycle
// against a transaction-level model of the unit.
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MISALIGN_EXC_EN
  localparam bit ExcOn = 1'b1;
`else
  localparam bit ExcOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        dmem_en;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_exc;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .dmem_en(dmem_en), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_exc(resp_exc)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int compared = 0;
  int mismatched = 0;
  logic [31:0] mem [64];
  logic [32:0] exp_q[$];          // {exc, rdata} of responses owed
  int          phase = 0;          // 0 idle, 1 memory access, 2 response
  logic [31:0] expAddr, expWdata;
  logic [3:0]  expBe;
  logic        expWe, expSigned;
  int          expSize, expOff;

  // stimulus knobs
  bit          randomMode = 1'b0;
  bit          pend = 1'b0;
  logic        pWe, pSigned;
  logic [1:0]  pSize;
  logic [31:0] pAddr, pWdata;
  int          ackDelay = 0, readyDelay = 0, accessCnt = 0, respCnt = 0;
  int          txDone = 0;

  // observations of the DUT for directed literal checks
  int          enHighCnt, rvHighCnt, readyBusyCnt;
  logic [31:0] obsAddr, obsWdata, obsRdata;
  logic [3:0]  obsBe;
  logic        obsExc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model reaction to an accepted request, from the size/alignment rules.
  task automatic model_accept();
    int nb;
    logic [31:0] eff;
    expSize   = (req_size == 2'd3) ? 2 : int'(req_size);
    nb        = 1 << expSize;
    expWe     = req_we;
    expSigned = req_signed;
    if ((req_addr % nb) != 0 && ExcOn) begin
      exp_q.push_back({1'b1, 32'd0});
      phase   = 2;
      respCnt = 0;
    end else begin
      eff      = req_addr - (req_addr % nb);
      expAddr  = eff - (eff % 4);
      expOff   = int'(eff % 4);
      expBe    = req_we ? 4'(((1 << nb) - 1) << expOff) : 4'd0;
      expWdata = (expSize == 0) ? req_wdata[7:0] * 32'h01010101 :
                 (expSize == 1) ? req_wdata[15:0] * 32'h00010001 : req_wdata;
      phase     = 1;
      accessCnt = 0;
    end
  endtask

  // Model reaction to the memory ack: update memory or compute load value.
  task automatic model_ack();
    logic [31:0] w, mask, v;
    int nbits;
    w = mem[expAddr[7:2]];
    if (expWe) begin
      for (int i = 0; i < 4; i++)
        if (expBe[i]) mem[expAddr[7:2]][8*i +: 8] = expWdata[8*i +: 8];
      exp_q.push_back({1'b0, 32'd0});
    end else begin
      nbits = 8 << expSize;
      if (expSize == 2) v = w;
      else begin
        mask = (32'd1 << nbits) - 32'd1;
        v = (w >> (8 * expOff)) & mask;
        if (expSigned && v[nbits-1]) v = v | ~mask;
      end
      exp_q.push_back({1'b0, v});
    end
  endtask

  // Compare every output against the model, and record observations.
  task automatic check_outputs();
    chk("req_ready", {31'd0, req_ready}, {31'd0, phase == 0});
    chk("dmem_en", {31'd0, dmem_en}, {31'd0, phase == 1});
    chk("dmem_be", {28'd0, dmem_be}, {28'd0, (phase == 1) ? expBe : 4'd0});
    if (phase == 1) begin
      chk("dmem_addr", dmem_addr, expAddr);
      chk("dmem_wdata", dmem_wdata, expWdata);
    end
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, phase == 2});
    if (phase == 2) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL resp_queue: got empty expected one entry");
      end else begin
        chk("resp_rdata", resp_rdata, exp_q[0][31:0]);
        chk("resp_exc", {31'd0, resp_exc}, {31'd0, exp_q[0][32]});
      end
    end
    if (dmem_en) begin
      enHighCnt++; obsAddr = dmem_addr; obsWdata = dmem_wdata; obsBe = dmem_be;
    end
    if (resp_valid) begin
      rvHighCnt++; obsRdata = resp_rdata; obsExc = resp_exc;
    end
    if (phase != 0) readyBusyCnt += int'(req_ready);
  endtask

  // Drive inputs for the coming edge.
  task automatic drive();
    if (phase == 0 && !pend && randomMode && $urandom_range(0, 1) == 1) begin
      pend = 1'b1; pWe = 1'($urandom_range(0, 1)); pSize = 2'($urandom_range(0, 3));
      pSigned = 1'($urandom_range(0, 1)); pAddr = $urandom_range(0, 255); pWdata = $urandom;
      ackDelay = $urandom_range(0, 3); readyDelay = $urandom_range(0, 2);
    end
    if (phase == 0 && pend) begin
      req_valid = 1'b1; req_we = pWe; req_size = pSize; req_signed = pSigned;
      req_addr = pAddr; req_wdata = pWdata;
    end else begin
      req_valid = (phase != 0 && randomMode) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    end
    if (phase == 1) begin
      dmem_ack = (accessCnt == ackDelay); dmem_rdata = mem[expAddr[7:2]];
    end else begin
      dmem_ack = randomMode ? ($urandom_range(0, 3) == 0) : 1'b0; dmem_rdata = $urandom;
    end
    if (phase == 2) resp_ready = (respCnt == readyDelay);
    else            resp_ready = 1'($urandom_range(0, 1));
  endtask

  // Advance the model with the inputs the DUT just sampled.
  task automatic update();
    case (phase)
      0: if (req_valid) begin model_accept(); pend = 1'b0; end
      1: if (dmem_ack) begin model_ack(); phase = 2; respCnt = 0; end
         else accessCnt++;
      default: if (resp_ready) begin void'(exp_q.pop_front()); phase = 0; txDone++; end
               else respCnt++;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive();
    @(posedge clk);
    update();
  endtask

  task automatic run_directed(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ad, input int rd);
    int start;
    pend = 1'b1; pWe = we; pSize = size; pSigned = sgn; pAddr = addr; pWdata = wdata;
    ackDelay = ad; readyDelay = rd; randomMode = 1'b0;
    enHighCnt = 0; rvHighCnt = 0; readyBusyCnt = 0;
    obsAddr = '0; obsWdata = '0; obsRdata = '0; obsBe = '0; obsExc = 1'b0;
    start = txDone;
    for (int i = 0; i < 40 && txDone == start; i++) step();
    if (txDone == start) begin
      compared++; mismatched++;
      $display("FAIL directed_timeout: got no response expected one within 40 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_dmem_en"}, {31'd0, dmem_en}, 32'd0);
    chk({tag, "_dmem_be"}, {28'd0, dmem_be}, 32'd0);
    chk({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_exc"}, {31'd0, resp_exc}, 32'd0);
  endtask

  task automatic quiet_inputs();
    req_valid = 1'b0; dmem_ack = 1'b0; resp_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h12F45678;            // word at 0x100 (and 0x200)

    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // signed byte load
    run_directed(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 0, 0);
    chk("sbyte_rdata", obsRdata, 32'hFFFFFFF4);
    chk("sbyte_be", {28'd0, obsBe}, 32'd0);
    chk("sbyte_addr", obsAddr, 32'h100);
    // unsigned half load
    run_directed(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 0);
    chk("uhalf_rdata", obsRdata, 32'h000012F4);
    // byte store into lane 3
    run_directed(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000AB, 0, 0);
    chk("sbst_be", {28'd0, obsBe}, 32'h8);
    chk("sbst_wdata", obsWdata, 32'hABABABAB);
    chk("sbst_rdata", obsRdata, 32'd0);
    // stalls, with size 11 acting as word
    run_directed(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 3, 2);
    chk("stall_en_cycles", enHighCnt, 32'd4);
    chk("stall_rv_cycles", rvHighCnt, 32'd3);
    chk("stall_req_ready", readyBusyCnt, 32'd0);
    chk("stall_rdata", obsRdata, 32'hABF45678);
    // signed half of the updated word
    run_directed(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1, 0);
    chk("shalf_rdata", obsRdata, 32'hFFFFABF4);
    // misaligned word
    run_directed(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, 0);
    if (ExcOn) begin
      chk("misalign_exc", {31'd0, obsExc}, 32'd1);
      chk("misalign_en_cycles", enHighCnt, 32'd0);
      chk("misalign_rdata", obsRdata, 32'd0);
    end else begin
      chk("misalign_addr", obsAddr, 32'h4);
      chk("misalign_exc", {31'd0, obsExc}, 32'd0);
    end

    // random traffic, then drain
    randomMode = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    randomMode = 1'b0;
    guard = 0;
    while ((phase != 0 || pend) && guard < 100) begin step(); guard++; end
    if (phase != 0 || pend) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: got busy expected idle within 100 cycles");
    end

    // reset in the middle of an access
    pend = 1'b1; pWe = 1'b0; pSize = 2'b10; pSigned = 1'b0; pAddr = 32'h100; pWdata = 32'h0;
    ackDelay = 1000; readyDelay = 0;
    guard = 0;
    while (phase != 1 && guard < 10) begin step(); guard++; end
    if (phase != 1) begin
      compared++; mismatched++;
      $display("FAIL midreset_setup: got no access expected one within 10 cycles");
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    phase = 0; pend = 1'b0; exp_q.delete();
    quiet_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    rvHighCnt = 0;
    for (int i = 0; i < 6; i++) step();
    chk("midreset_no_resp", rvHighCnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
